// File: rtl/cmd_packet_encoder.sv
// cmd_packet_encoder: buffers host requests in a FIFO and serialises them into decoder packet bytes while tracking CALL depth
module cmd_packet_encoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic [7:0] pkt_data,
  output logic       pkt_last,
  output logic [2:0] call_depth,
  output logic       err_ovf,
  output logic       err_unf,
  output logic       idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] MAX_DEPTH = 3'(STACK_DEPTH);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_nx;
  logic [13:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [13:0] head;
  logic [1:0] op_q;
  logic [7:0] hdr_q, opd_q;
  logic full, empty, push, pop, drop_ovf, drop_unf, issue;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready = !full;
  assign push = req_valid && req_ready;
  assign head = mem[rd_ptr[AW-1:0]];
  assign pop = state == IDLE && !empty;
  assign drop_ovf = pop && head[13:12] == 2'b10 && call_depth == MAX_DEPTH;
  assign drop_unf = pop && head[13:12] == 2'b11 && call_depth == 3'd0;
  assign issue = pop && !drop_ovf && !drop_unf;
  assign idle = state == IDLE && empty;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (issue ? HDR : IDLE)
             : state == HDR  ? (pkt_ready ? (op_q == 2'b00 ? DATA : IDLE) : HDR)
             : (pkt_ready ? IDLE : DATA);
    pkt_valid = state != IDLE;
    pkt_data = state == HDR ? hdr_q : state == DATA ? opd_q : 8'h00;
    pkt_last = state == DATA || (state == HDR && op_q != 2'b00);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {req_op, req_addr, req_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      op_q <= 2'b00;
      hdr_q <= 8'h00;
      opd_q <= 8'h00;
      call_depth <= 3'd0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      err_ovf <= drop_ovf;
      err_unf <= drop_unf;
      if (issue) begin
        op_q <= head[13:12];
        // RETURN carries no target, so its address nibble is zeroed
        hdr_q <= head[13:12] == 2'b11 ? 8'h0C : {head[11:8], head[13:12], 2'b00};
        opd_q <= head[7:0];
      end
      if (state == HDR && pkt_ready)
        call_depth <= op_q == 2'b10 ? call_depth + 3'd1 : op_q == 2'b11 ? call_depth - 3'd1 : call_depth;
    end
endmodule

// File: doc/cmd_packet_encoder.md
Name: cmd_packet_encoder

Overview:
- Transmit side of the 8-bit instruction-packet interface consumed by the command decoder (PC + return-stack block).
- Accepts high-level requests (op, target address, operand) from a host/sequencer over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each request into decoder packet format, one byte per accepted beat.
- Tracks call depth so no CALL is emitted that would overflow the decoder's return stack, and no RETURN is emitted against an empty stack.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.
- STACK_DEPTH, 4, maximum outstanding CALLs (matches the decoder return-stack depth).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  host request valid
- req_ready  out  1  FIFO can accept; equals !fifo_full
- req_op  in  2  00 EXECUTE, 01 JUMP, 10 CALL, 11 RETURN
- req_addr  in  4  target address (ignored for RETURN)
- req_data  in  8  operand byte (EXECUTE only)
- pkt_valid  out  1  packet byte valid
- pkt_ready  in  1  decoder accepts byte
- pkt_data  out  8  packet byte
- pkt_last  out  1  final byte of the current packet
- call_depth  out  3  committed outstanding CALL count, 0..STACK_DEPTH
- err_ovf  out  1  one-cycle pulse: CALL dropped, depth already at STACK_DEPTH
- err_unf  out  1  one-cycle pulse: RETURN dropped, depth 0
- idle  out  1  FSM in IDLE and FIFO empty

Behaviour:
- Reset: FIFO emptied, FSM=IDLE. Outputs: pkt_valid=0, pkt_data=8'h00, pkt_last=0, call_depth=0, err_ovf=0, err_unf=0, req_ready=1, idle=1.
- Reset mid-packet abandons the packet; no partial bytes follow after reset.
- Header byte format: pkt_data[7:4]=req_addr, pkt_data[3:0]=opcode. Opcodes: EXECUTE 4'b0000, JUMP 4'b0100, CALL 4'b1000, RETURN 4'b1100.
- RETURN header is always 8'h0C; its address field is forced to 0.
- FIFO push on req_valid && req_ready. Push and pop in the same cycle are allowed.
- FSM states: IDLE, HDR, DATA.
- IDLE, FIFO non-empty, inspect head:
  - CALL with call_depth==STACK_DEPTH: pop, pulse err_ovf, stay IDLE.
  - RETURN with call_depth==0: pop, pulse err_unf, stay IDLE.
  - Otherwise: pop, latch header and operand into output registers, go to HDR.
  - Exactly one head is inspected per cycle.
- HDR: pkt_valid=1, pkt_data=header, pkt_last=(op!=EXECUTE).
  - On pkt_ready: CALL increments call_depth; RETURN decrements it.
  - Then go to DATA if EXECUTE, else IDLE.
- DATA: pkt_valid=1, pkt_data=operand, pkt_last=1. On pkt_ready go to IDLE.
- pkt_data and pkt_last hold stable while pkt_valid && !pkt_ready. pkt_valid never drops without a handshake.
- Latency: request handshake at edge E0 into an empty FIFO gives pkt_valid high after edge E1.
- Throughput: IDLE costs one cycle between packets (no back-to-back bypass). Single-byte packet: 2 cycles; EXECUTE: 3 cycles.
- call_depth changes only on header acceptance. Because only one packet is in flight, the IDLE check always sees committed depth.
- Capacity: FIFO_DEPTH entries plus one in the output register.
- Dropped requests never produce pkt_valid.
- err_ovf and err_unf are never asserted in the same cycle.

Test Plan:
- CALL addr 5, pkt_ready=1 -> one beat pkt_data=8'h58 with pkt_last=1; call_depth 0->1 on acceptance; pkt_valid first high the cycle after edge E1.
- JUMP addr A, then RETURN -> beats 8'hA4 (last), then 8'h0C (last); call_depth unchanged by JUMP; RETURN issued at depth 1 goes 1->0.
- EXECUTE addr 3 data 8'h7E, pkt_ready low 3 cycles per beat -> 8'h30 (last=0) held stable 3 cycles, then 8'h7E (last=1) held; no depth change.
- Five consecutive CALLs (addrs 1..5) -> headers 8'h18, 8'h28, 8'h38, 8'h48 emitted; depth reaches 4; fifth CALL pulses err_ovf once with no packet; then RETURN -> 8'h0C, depth 3.
- RETURN from reset -> err_unf pulse, no pkt_valid, call_depth stays 0; idle returns high.
- pkt_ready=0, six back-to-back JUMP requests -> 5 accepted, req_ready low on the sixth. Release pkt_ready -> 5 packets in order.
- Assert rst while in DATA -> all outputs take reset values immediately, FIFO empty.
